restoring_div_ctrl: RTL
=======================

# restoring_div_ctrl

Sequential control and datapath for the 8-bit unsigned restoring divider. It holds the A (partial remainder), Q (dividend/quotient) and M (divisor) registers and runs one shift/subtract/restore iteration per clock. It drives the operands of the external 8-bit two's-complement subtractor stage and consumes that stage's difference, so it sits directly around the subtractor. It delivers quotient and remainder through a start/done handshake.

## Interface
- WIDTH, 8: operand width. Fixed at 8 to match the subtractor stage; other values are unsupported.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- dividend  input  8  unsigned dividend; sampled with start
- divisor  input  8  unsigned divisor; sampled with start; legal range 1..127
- sub_a  output  8  subtractor minuend, combinational: {A[6:0], Q[7]}
- sub_m  output  8  subtractor subtrahend, combinational: M
- sub_diff  input  8  subtractor result, sub_a − sub_m mod 256; must be combinational from sub_a/sub_m within the cycle
- quotient  output  8  Q register
- remainder  output  8  A register
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- err  output  1  registered; set on an illegal divisor, cleared on the next accepted start

## Operation
- States are IDLE, RUN and DONE. On reset the block is in IDLE.
- **IDLE with start=1:**
  - If divisor==0 or divisor[7]==1: A←dividend, Q←8'hFF, M←divisor, err←1, next state DONE.
  - Otherwise: A←0, Q←dividend, M←divisor, cnt←0, err←0, next state RUN.
- **IDLE with start=0:** all registers hold.
- **RUN, each cycle:**
  - The left shift {A,Q} is implied by sub_a.
  - If sub_diff[7]==1 (restore): A←{A[6:0],Q[7]}, Q←{Q[6:0],1'b0}.
  - Otherwise: A←sub_diff, Q←{Q[6:0],1'b1}.
  - cnt increments. After the 8th iteration (cnt==7), next state is DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE. A, Q, M and err hold.
- **Why sub_diff[7] is a valid sign:** with M≤127, A<M holds throughout. The shifted value is ≤2M−1, so the true difference lies in [−M, M−1] ⊂ [−128, 127]. The 8-bit sign bit is therefore exact. This is the reason divisor[7] must be 0.
- **Result validity:** quotient and remainder are valid from the DONE cycle until the next accepted start. They show intermediate values during RUN and must not be consumed then.
- **start outside IDLE:** ignored in RUN and in DONE, with no queuing. A start must be held or reissued in IDLE.
- **Subtractor stage:** purely combinational and external. This block contains no subtractor of its own.

## Timing
- **Reset values** (asynchronous, while rst=1):
  - State IDLE; A, Q, M and cnt = 0.
  - quotient=0, remainder=0, busy=0, done=0, err=0, sub_a=0, sub_m=0.
- **Reset mid-RUN:** the block aborts immediately to IDLE with all-zero outputs. No done is produced for the aborted operation.
- **Legal operation:**
  - start is sampled at edge E0, and busy=1 from E0.
  - Iterations complete at edges E1..E8.
  - The state is DONE after E8, so done=1 in the cycle E8–E9, and busy=0 in that cycle.
  - The block is back in IDLE after E9. The earliest next start is sampled at E9.
  - Latency from the start edge to the done cycle is 8 clocks; throughput is one division per 9 clocks.
- **Illegal divisor:** start is sampled at E0, done=1 with err=1 in the cycle E0–E1, and busy never asserts.
- **Combinational path:** A/Q/M → sub_a/sub_m → external subtractor → sub_diff → A/Q D-input must close in one cycle.

## Test plan
- dividend=100, divisor=7 → after 8 busy cycles, done=1 with quotient=14, remainder=2, err=0; busy low in the done cycle.
- dividend=255, divisor=127 → quotient=2, remainder=1. Also dividend=255, divisor=1 → quotient=255, remainder=0.
- dividend=5, divisor=9 → quotient=0, remainder=5; every iteration restores (sub_diff[7]=1 on all 8 cycles).
- divisor=0, dividend=42 → done in the cycle after the start edge with err=1, quotient=8'hFF, remainder=42, busy never high. Repeat with divisor=200: same response.
- start pulsed again during cycle 3 of RUN with a different operand pair → ignored; the original result is delivered at the original time. A later start in IDLE clears err and runs normally.
- rst asserted asynchronously at mid-RUN iteration 4 → all outputs 0 immediately, no done pulse. After rst deasserts, 200/13 completes with quotient=15, remainder=5.

Source files
------------

// File: rtl/restoring_div_ctrl.sv
// restoring_div_ctrl: control and register file for an 8-bit unsigned restoring divider.
// Holds A (partial remainder), Q (dividend -> quotient) and M (divisor), feeds an external
// combinational subtractor, and performs one shift/subtract/restore step per clock.
module restoring_div_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_m,
  input  logic [WIDTH-1:0] sub_diff,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CntW-1:0]  r_cnt;
  logic             r_err;

  logic [WIDTH-1:0] w_a_d;
  logic [WIDTH-1:0] w_q_d;
  logic [WIDTH-1:0] w_m_d;
  logic [CntW-1:0]  w_cnt_d;
  logic             w_err_d;

  logic [WIDTH-1:0] w_shift_a;
  logic             w_illegal;
  logic             w_restore;

  // Left shift of {A,Q} by one: the new A candidate before subtraction.
  assign w_shift_a = {r_a[WIDTH-2:0], r_q[WIDTH-1]};

  // The sign bit of the 8-bit difference is exact only while M <= 127, so a divisor with the
  // top bit set is rejected along with zero.
  assign w_illegal = (divisor == '0) | divisor[WIDTH-1];

  // Negative trial difference means the shifted A was smaller than M: keep it.
  assign w_restore = sub_diff[WIDTH-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and datapath next values; everything holds unless a case overrides it.
  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_q_d     = r_q;
    w_m_d     = r_m;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_m_d = divisor;
          if (w_illegal) begin
            w_a_d     = dividend;
            w_q_d     = '1;
            w_err_d   = 1'b1;
            w_state_d = StDone;
          end else begin
            w_a_d     = '0;
            w_q_d     = dividend;
            w_cnt_d   = '0;
            w_err_d   = 1'b0;
            w_state_d = StRun;
          end
        end
      end
      StRun: begin
        if (w_restore) begin
          w_a_d = w_shift_a;
          w_q_d = {r_q[WIDTH-2:0], 1'b0};
        end else begin
          w_a_d = sub_diff;
          w_q_d = {r_q[WIDTH-2:0], 1'b1};
        end
        w_cnt_d = r_cnt + 1'b1;
        if (r_cnt == LastIter) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Datapath registers: A, Q, M, iteration counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_a   <= w_a_d;
      r_q   <= w_q_d;
      r_m   <= w_m_d;
      r_cnt <= w_cnt_d;
      r_err <= w_err_d;
    end
  end

  assign sub_a     = w_shift_a;
  assign sub_m     = r_m;
  assign quotient  = r_q;
  assign remainder = r_a;
  assign busy      = (r_state == StRun);
  assign done      = (r_state == StDone);
  assign err       = r_err;

endmodule
